// File: rtl/iq_gain_sat_pipe_if.sv
// rtl/iq_gain_sat_pipe_if.sv - I/Q sample bus into and out of the gain/saturation pipe
interface iq_gain_sat_pipe_if #(
    parameter int IN_W   = 32,
    parameter int OUT_W  = 16,
    parameter int GAIN_W = 5,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_sof;
    logic [IN_W-1:0]   in_i;
    logic [IN_W-1:0]   in_q;
    logic [GAIN_W-1:0] gain;
    logic              round_en;
    logic              out_valid;
    logic              out_sof;
    logic [OUT_W-1:0]  out_i;
    logic [OUT_W-1:0]  out_q;
    logic              out_sat;
    logic [CNT_W-1:0]  sat_cnt;
    logic              sat_cnt_valid;

    modport master (
        output in_valid, in_sof, in_i, in_q, gain, round_en,
        input  out_valid, out_sof, out_i, out_q, out_sat, sat_cnt, sat_cnt_valid
    );

    modport slave (
        input  in_valid, in_sof, in_i, in_q, gain, round_en,
        output out_valid, out_sof, out_i, out_q, out_sat, sat_cnt, sat_cnt_valid
    );
endinterface

// File: rtl/iq_gain_sat_pipe.sv
// rtl/iq_gain_sat_pipe.sv - power-of-two I/Q gain with rounding, saturation and per-frame stats
module iq_gain_sat_pipe #(
    parameter int IN_W     = 32,
    parameter int OUT_W    = 16,
    parameter int GAIN_W   = 5,
    parameter int GAIN_RST = 0,
    parameter int CNT_W    = 16
) (
    input logic                clk,
    input logic                rst_n,
    iq_gain_sat_pipe_if.slave  bus
);
    localparam logic [GAIN_W-1:0] MAXG_W = GAIN_W'(IN_W - OUT_W);

    typedef logic signed [IN_W:0] wide_t;

    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              rnd_q, rnd_d;
    logic [GAIN_W-1:0] sh;
    logic              v1_q, sof1_q;
    wide_t             yi1_q, yq1_q, yi_d, yq_d;
    logic              out_valid_q, out_sof_q, out_sat_q, out_sat_d;
    logic [OUT_W-1:0]  out_i_q, out_q_q, out_i_d, out_q_d;
    logic [OUT_W-1:0]  sat_i_val, sat_q_val;
    logic              sat_i, sat_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, sat_cnt_q, sat_cnt_d;
    logic              scv_q, scv_d, first_q, first_d;

    // Extra top bit keeps x + 2^(sh-1) from wrapping for the most positive input.
    function automatic wide_t scale(input logic [IN_W-1:0] x, input logic [GAIN_W-1:0] s,
                                    input logic rnd);
        wide_t t;
        t = {x[IN_W-1], x};
        if (rnd && s != '0) begin
            t = t + (wide_t'(1) << (s - GAIN_W'(1)));
        end
        return t >>> s;
    endfunction

    function automatic logic [OUT_W:0] saturate(input wide_t y);
        if (y[IN_W:OUT_W-1] == {(IN_W-OUT_W+2){y[IN_W]}}) begin
            return {1'b0, y[OUT_W-1:0]};
        end else if (y[IN_W]) begin
            return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

    always_comb begin
        gain_d = gain_q;
        rnd_d  = rnd_q;
        if (bus.in_valid && bus.in_sof) begin
            gain_d = (bus.gain > MAXG_W) ? MAXG_W : bus.gain;
            rnd_d  = bus.round_en;
        end
        sh   = MAXG_W - gain_d;
        yi_d = scale(bus.in_i, sh, rnd_d);
        yq_d = scale(bus.in_q, sh, rnd_d);
    end

    always_comb begin
        {sat_i, sat_i_val} = saturate(yi1_q);
        {sat_q, sat_q_val} = saturate(yq1_q);
        out_i_d   = out_i_q;
        out_q_d   = out_q_q;
        out_sat_d = out_sat_q;
        if (v1_q) begin
            out_i_d   = sat_i_val;
            out_q_d   = sat_q_val;
            out_sat_d = sat_i | sat_q;
        end
    end

    // Frame statistics: the report of the closing frame is aligned with the new frame's out_sof.
    always_comb begin
        cnt_d     = cnt_q;
        sat_cnt_d = sat_cnt_q;
        scv_d     = 1'b0;
        first_d   = first_q;
        if (v1_q) begin
            if (sof1_q) begin
                if (!first_q) begin
                    sat_cnt_d = cnt_q;
                    scv_d     = 1'b1;
                end
                cnt_d   = CNT_W'(out_sat_d);
                first_d = 1'b0;
            end else if (out_sat_d && !(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain_q      <= GAIN_W'(GAIN_RST);
            rnd_q       <= 1'b0;
            v1_q        <= 1'b0;
            sof1_q      <= 1'b0;
            yi1_q       <= '0;
            yq1_q       <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_sat_q   <= 1'b0;
            cnt_q       <= '0;
            sat_cnt_q   <= '0;
            scv_q       <= 1'b0;
            first_q     <= 1'b1;
        end else begin
            gain_q      <= gain_d;
            rnd_q       <= rnd_d;
            v1_q        <= bus.in_valid;
            sof1_q      <= bus.in_valid && bus.in_sof;
            if (bus.in_valid) begin
                yi1_q <= yi_d;
                yq1_q <= yq_d;
            end
            out_valid_q <= v1_q;
            out_sof_q   <= v1_q && sof1_q;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_sat_q   <= out_sat_d;
            cnt_q       <= cnt_d;
            sat_cnt_q   <= sat_cnt_d;
            scv_q       <= scv_d;
            first_q     <= first_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_sof       = out_sof_q;
    assign bus.out_i         = out_i_q;
    assign bus.out_q         = out_q_q;
    assign bus.out_sat       = out_sat_q;
    assign bus.sat_cnt       = sat_cnt_q;
    assign bus.sat_cnt_valid = scv_q;
endmodule
